// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: op codes, the legal funct list,
// FSM state encoding and the decode result record.
package alu_pkg;

    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_ADDU = 6'b100001;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_SUBU = 6'b100011;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_SLL  = 6'b000001;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SRA  = 6'b000011;

    localparam int NUM_LEGAL = 10;

    // Every funct the unit will issue; anything else is reported illegal.
    localparam logic [NUM_LEGAL-1:0][5:0] LEGAL_FUNCTS = {
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND,
        OP_OR,  OP_XOR,  OP_SLL, OP_SRL,  OP_SRA
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    typedef struct packed {
        logic        legal;
        logic [5:0]  op_code;
        logic [31:0] operand1;
        logic [31:0] operand2;
    } dec_t;

    function automatic logic funct_is_legal(input logic [5:0] funct);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_LEGAL; i++)
            if (LEGAL_FUNCTS[i] == funct) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic funct_is_shift(input logic [5:0] funct);
        return (funct == OP_SLL) || (funct == OP_SRL) || (funct == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational funct decode: legality check and operand selection.
// Shifts take the value from rt and the amount from shamt; everything
// else operates on rs and rt.
module alu_funct_decode
    import alu_pkg::*;
(
    input  logic [10:0] instr_lo,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output dec_t        dec
);

    logic [5:0] funct;
    logic [4:0] shamt;

    assign funct = instr_lo[5:0];
    assign shamt = instr_lo[10:6];

    // Decode legality and pick operands for the op class.
    always_comb begin
        dec          = '0;
        dec.legal    = funct_is_legal(funct);
        dec.op_code  = funct;
        if (funct_is_shift(funct)) begin
            dec.operand1 = rt_data;
            dec.operand2 = {27'd0, shamt};
        end else begin
            dec.operand1 = rs_data;
            dec.operand2 = rt_data;
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue unit: accepts one R-type op at a time, drives registered
// operands to an external combinational ALU for a full cycle, captures the
// response and holds it until downstream takes it.
// Optional feature: define ALU_ISSUE_OVF_TRAP_EN to suppress writeback of
// signed ADD/SUB results that overflow.
module alu_issue_unit
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    output logic [5:0]  alu_op_code,
    output logic [31:0] alu_operand1,
    output logic [31:0] alu_operand2,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_overflow,
    output logic [4:0]  out_rd,
    output logic        out_wr_en,
    output logic        out_illegal,
    output logic [15:0] issue_count
);

    state_t     state_q, state_d;
    dec_t       dec;
    logic       accept;
    logic [4:0] rd_q;
    logic       wr_en_cap;
    logic       unused_instr_hi;

    assign unused_instr_hi = ^in_instr[31:16];

    alu_funct_decode u_decode (
        .instr_lo (in_instr[10:0]),
        .rs_data  (in_rs_data),
        .rt_data  (in_rt_data),
        .dec      (dec)
    );

    // Ready only while idle and out of reset.
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign accept    = in_valid && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_HOLD);

    // Writeback enable for a captured legal result.
    always_comb begin
        wr_en_cap = 1'b1;
`ifdef ALU_ISSUE_OVF_TRAP_EN
        if (alu_overflow && ((alu_op_code == OP_ADD) || (alu_op_code == OP_SUB)))
            wr_en_cap = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = dec.legal ? ST_ISSUE : ST_HOLD;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_HOLD;
            ST_HOLD:    if (out_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Issue registers and issue counter, loaded on a legal accept only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_code  <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            rd_q         <= '0;
            issue_count  <= '0;
        end else if (accept && dec.legal) begin
            alu_op_code  <= dec.op_code;
            alu_operand1 <= dec.operand1;
            alu_operand2 <= dec.operand2;
            rd_q         <= in_instr[15:11];
            if (issue_count != 16'hFFFF)
                issue_count <= issue_count + 16'd1;
        end
    end

    // Result registers: filled in CAPTURE, or with an illegal marker
    // straight from IDLE; untouched in HOLD so they stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_rd       <= '0;
            out_wr_en    <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (accept && !dec.legal) begin
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_rd       <= in_instr[15:11];
            out_wr_en    <= 1'b0;
            out_illegal  <= 1'b1;
        end else if (state_q == ST_CAPTURE) begin
            out_result   <= alu_result;
            out_zero     <= alu_zero;
            out_overflow <= alu_overflow;
            out_rd       <= rd_q;
            out_wr_en    <= wr_en_cap;
            out_illegal  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit with a behavioural ALU attached.
module tb_alu_issue_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_rs_data = '0;
    logic [31:0] in_rt_data = '0;
    logic [5:0]  alu_op_code;
    logic [31:0] alu_operand1, alu_operand2;
    logic [31:0] alu_result;
    logic        alu_zero, alu_overflow;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_zero, out_overflow;
    logic [4:0]  out_rd;
    logic        out_wr_en, out_illegal;
    logic [15:0] issue_count;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic [4:0]  rd;
        logic        wr_en;
        logic        illegal;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_count = 0;

    always #5 clk = ~clk;

    alu_issue_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .alu_op_code(alu_op_code), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_overflow(out_overflow), .out_rd(out_rd),
        .out_wr_en(out_wr_en), .out_illegal(out_illegal), .issue_count(issue_count)
    );

    // Reference ALU: {signed overflow, result}.
    function automatic logic [32:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        r = '0;
        v = 1'b0;
        case (op)
            6'b100000, 6'b100001: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            6'b100010, 6'b100011: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b000001: r = a << b[4:0];
            6'b000010: r = a >> b[4:0];
            6'b000011: r = $signed(a) >>> b[4:0];
            default:   r = '0;
        endcase
        return {v, r};
    endfunction

    always_comb begin
        {alu_overflow, alu_result} = ref_alu(alu_op_code, alu_operand1, alu_operand2);
        alu_zero = (alu_result == 32'd0);
    end

    function automatic logic [31:0] mk(input logic [5:0] funct, input logic [4:0] shamt, input logic [4:0] rd);
        return {16'hA5C3, rd, shamt, funct};
    endfunction

    function automatic logic tb_legal(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
            6'b100101, 6'b100110, 6'b000001, 6'b000010, 6'b000011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic tb_shift(input logic [5:0] f);
        return (f == 6'b000001) || (f == 6'b000010) || (f == 6'b000011);
    endfunction

    function automatic logic tb_trap(input logic [5:0] f, input logic v);
`ifdef ALU_ISSUE_OVF_TRAP_EN
        return v && ((f == 6'b100000) || (f == 6'b100010));
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t make_exp(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        exp_t        e;
        logic [32:0] vr;
        logic [5:0]  f;
        f = instr[5:0];
        e = '0;
        e.rd = instr[15:11];
        if (!tb_legal(f)) begin
            e.illegal = 1'b1;
        end else begin
            vr = tb_shift(f) ? ref_alu(f, rt, {27'd0, instr[10:6]}) : ref_alu(f, rs, rt);
            e.result = vr[31:0];
            e.ovf    = vr[32];
            e.zero   = (vr[31:0] == 32'd0);
            e.wr_en  = !tb_trap(f, vr[32]);
        end
        return e;
    endfunction

    task automatic run_op(input string name, input logic [31:0] instr, input logic [31:0] rs,
                          input logic [31:0] rt, input exp_t e, input logic [5:0] eop,
                          input logic [31:0] eo1, input logic [31:0] eo2, input int hold);
        int   edges;
        int   exp_lat;
        exp_t got;
        sb.push_back(e);
        exp_lat = e.illegal ? 1 : 3;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        in_valid = 1'b1; in_instr = instr; in_rs_data = rs; in_rt_data = rt;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0; in_instr = $urandom; in_rs_data = $urandom; in_rt_data = $urandom;
        if (!e.illegal) begin
            if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
            n_tests++;
            if ({alu_op_code, alu_operand1, alu_operand2} !== {eop, eo1, eo2}) begin
                n_fail++;
                $display("FAIL %s alu regs: got op=%b o1=%h o2=%h want op=%b o1=%h o2=%h",
                         name, alu_op_code, alu_operand1, alu_operand2, eop, eo1, eo2);
            end
        end
        n_tests++;
        if (issue_count !== exp_count) begin
            n_fail++;
            $display("FAIL %s issue_count: got %0d want %0d", name, issue_count, exp_count);
        end
        while (out_valid !== 1'b1 && edges < 10) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        n_tests++;
        got = sb.pop_front();
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s out_valid timeout: got %b want 1", name, out_valid);
        end else begin
            if (edges != exp_lat) begin
                n_fail++;
                $display("FAIL %s latency: got %0d edges want %0d", name, edges, exp_lat);
            end
            n_tests++;
            if ({out_result, out_zero, out_overflow, out_rd, out_wr_en, out_illegal} !== got) begin
                n_fail++;
                $display("FAIL %s result: got res=%h z=%b v=%b rd=%0d we=%b ill=%b want res=%h z=%b v=%b rd=%0d we=%b ill=%b",
                         name, out_result, out_zero, out_overflow, out_rd, out_wr_en, out_illegal,
                         got.result, got.zero, got.ovf, got.rd, got.wr_en, got.illegal);
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_tests++;
            if ({out_valid, in_ready, out_result, out_zero, out_overflow, out_rd, out_wr_en, out_illegal}
                !== {1'b1, 1'b0, got}) begin
                n_fail++;
                $display("FAIL %s hold cycle %0d: got vld=%b rdy=%b res=%h we=%b ill=%b want vld=1 rdy=0 res=%h we=%b ill=%b",
                         name, i, out_valid, in_ready, out_result, out_wr_en, out_illegal,
                         got.result, got.wr_en, got.illegal);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s release: got vld=%b rdy=%b want vld=0 rdy=1", name, out_valid, in_ready);
        end
    endtask

    task automatic check_all_zero(input string name, input logic exp_ready);
        n_tests++;
        if ({alu_op_code, alu_operand1, alu_operand2, out_valid, out_result, out_zero, out_overflow,
             out_rd, out_wr_en, out_illegal, issue_count} !== '0 || in_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL %s outputs: got op=%b o1=%h o2=%h vld=%b res=%h rd=%0d we=%b ill=%b cnt=%0d rdy=%b want all 0 rdy=%b",
                     name, alu_op_code, alu_operand1, alu_operand2, out_valid, out_result, out_rd,
                     out_wr_en, out_illegal, issue_count, in_ready, exp_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        check_all_zero("reset_low", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all_zero("reset_release", 1'b1);
        exp_count = 0;
    endtask

    task automatic test_add();
        exp_t e;
        e = '{result: 32'd145, zero: 1'b0, ovf: 1'b0, rd: 5'd7, wr_en: 1'b1, illegal: 1'b0};
        run_op("add", mk(6'b100000, 5'd0, 5'd7), 32'd100, 32'd45, e, 6'b100000, 32'd100, 32'd45, 0);
    endtask

    task automatic test_sub_zero();
        exp_t e;
        e = '{result: 32'd0, zero: 1'b1, ovf: 1'b0, rd: 5'd3, wr_en: 1'b1, illegal: 1'b0};
        run_op("sub_zero", mk(6'b100010, 5'd0, 5'd3), 32'd45, 32'd45, e, 6'b100010, 32'd45, 32'd45, 0);
    endtask

    task automatic test_sll();
        logic [4:0] sh[4];
        exp_t e;
        sh[0] = 5'd0; sh[1] = 5'd1; sh[2] = 5'd5; sh[3] = 5'd31;
        for (int i = 0; i < 4; i++) begin
            e = '{result: 32'd1 << sh[i], zero: 1'b0, ovf: 1'b0, rd: 5'd9, wr_en: 1'b1, illegal: 1'b0};
            run_op($sformatf("sll_%0d", sh[i]), mk(6'b000001, sh[i], 5'd9), 32'hDEADBEEF, 32'd1, e,
                   6'b000001, 32'd1, {27'd0, sh[i]}, 0);
        end
    endtask

    task automatic test_overflow();
        exp_t e;
`ifdef ALU_ISSUE_OVF_TRAP_EN
        e = '{result: 32'h80000000, zero: 1'b0, ovf: 1'b1, rd: 5'd12, wr_en: 1'b0, illegal: 1'b0};
`else
        e = '{result: 32'h80000000, zero: 1'b0, ovf: 1'b1, rd: 5'd12, wr_en: 1'b1, illegal: 1'b0};
`endif
        run_op("add_ovf", mk(6'b100000, 5'd0, 5'd12), 32'h7FFFFFFF, 32'd1, e, 6'b100000, 32'h7FFFFFFF, 32'd1, 0);
        // Unsigned add with the same operands is never trapped.
        e = '{result: 32'h80000000, zero: 1'b0, ovf: 1'b1, rd: 5'd13, wr_en: 1'b1, illegal: 1'b0};
        run_op("addu_ovf", mk(6'b100001, 5'd0, 5'd13), 32'h7FFFFFFF, 32'd1, e, 6'b100001, 32'h7FFFFFFF, 32'd1, 0);
    endtask

    task automatic test_illegal_hold();
        exp_t e;
        e = '{result: 32'd0, zero: 1'b0, ovf: 1'b0, rd: 5'd21, wr_en: 1'b0, illegal: 1'b1};
        run_op("illegal", mk(6'b111111, 5'd4, 5'd21), 32'd5, 32'd6, e, 6'd0, 32'd0, 32'd0, 5);
        e = '{result: 32'hFF00FF00, zero: 1'b0, ovf: 1'b0, rd: 5'd30, wr_en: 1'b1, illegal: 1'b0};
        run_op("xor_hold", mk(6'b100110, 5'd0, 5'd30), 32'hFFFF0000, 32'h00FFFF00, e,
               6'b100110, 32'hFFFF0000, 32'h00FFFF00, 5);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; in_instr = mk(6'b100000, 5'd0, 5'd4); in_rs_data = 32'd10; in_rt_data = 32'd20;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid", 1'b0);
        exp_count = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        e = '{result: 32'd3, zero: 1'b0, ovf: 1'b0, rd: 5'd2, wr_en: 1'b1, illegal: 1'b0};
        run_op("after_reset", mk(6'b100101, 5'd0, 5'd2), 32'd1, 32'd2, e, 6'b100101, 32'd1, 32'd2, 0);
    endtask

    task automatic test_back_to_back();
        logic [5:0]  fl[11];
        logic [31:0] instr, rs, rt;
        logic [5:0]  f;
        fl = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
               6'b100110, 6'b000001, 6'b000010, 6'b000011, 6'b011111};
        for (int i = 0; i < 12; i++) begin
            f     = fl[$urandom_range(0, 10)];
            instr = mk(f, 5'($urandom), 5'($urandom));
            rs    = $urandom;
            rt    = $urandom;
            run_op($sformatf("b2b_%0d", i), instr, rs, rt, make_exp(instr, rs, rt), f,
                   tb_shift(f) ? rt : rs, tb_shift(f) ? {27'd0, instr[10:6]} : rt, i % 2);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_zero();
        test_sll();
        test_overflow();
        test_illegal_hold();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: upstream presents an instruction.
REQ-004 SHALL have port in_ready, output, 1 bit: unit accepts an instruction this cycle.
REQ-005 SHALL have port in_instr, input, 32 bits: R-type word; funct [5:0], shamt [10:6], rd [15:11].
REQ-006 SHALL have port in_rs_data, input, 32 bits: rs register value.
REQ-007 SHALL have port in_rt_data, input, 32 bits: rt register value.
REQ-008 SHALL have port alu_op_code, output, 6 bits: registered op_code driven to the ALU.
REQ-009 SHALL have port alu_operand1, output, 32 bits: registered ALU operand1.
REQ-010 SHALL have port alu_operand2, output, 32 bits: registered ALU operand2.
REQ-011 SHALL have ports alu_result (32 bits), alu_zero (1 bit) and alu_overflow (1 bit), all inputs: combinational ALU response.
REQ-012 SHALL have port out_valid, output, 1 bit: a captured result is held.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream takes the result.
REQ-014 SHALL have ports out_result (32 bits), out_zero (1), out_overflow (1), out_rd (5) and out_wr_en (1), all outputs: captured result and writeback control.
REQ-015 SHALL have port out_illegal, output, 1 bit: the accepted funct is unsupported.
REQ-016 SHALL have port issue_count, output, 16 bits: number of ops issued to the ALU.

Function
REQ-017 SHALL decode funct: 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU, 100100 AND, 100101 OR, 100110 XOR, 000001 SLL, 000010 SRL, 000011 SRA; alu_op_code = funct.
REQ-018 SHALL set operand1=rs and operand2=rt for arithmetic and logic ops; operand1=rt and operand2=zero-extended shamt for shift ops.
REQ-019 SHALL implement an FSM with states IDLE, ISSUE, CAPTURE and HOLD; in_ready=1 only in IDLE.
REQ-020 SHALL load alu_* registers and move IDLE->ISSUE on in_valid&in_ready with a legal funct.
REQ-021 SHALL move ISSUE->CAPTURE after one cycle, so ALU inputs are stable for a full cycle.
REQ-022 SHALL latch alu_result, alu_zero and alu_overflow into out_* in CAPTURE and move to HOLD; out_valid is 1 from the cycle after CAPTURE.
REQ-023 SHALL hold out_* stable in HOLD while out_valid&!out_ready, and move HOLD->IDLE on out_ready; accept-to-out_valid latency is 3 edges.
REQ-024 SHALL go IDLE->HOLD on an illegal funct, with out_illegal=1, out_wr_en=0, out_result=0, no ALU issue and issue_count unchanged.
REQ-025 SHALL set out_rd=instr[15:11] and out_wr_en=1 for legal ops, except where REQ-032 applies.
REQ-026 SHALL increment issue_count on each IDLE->ISSUE transition, saturating at 0xFFFF.
REQ-027 SHALL ignore in_instr, in_rs_data and in_rt_data outside IDLE; alu_* hold their values until the next accept.

Reset
REQ-028 SHALL return to IDLE on rst_n low at any time, including mid-operation, and discard any in-flight op.
REQ-029 SHALL reset all outputs to 0 (in_ready=1 once rst_n deasserts), including alu_op_code, operands and issue_count.

Configuration
REQ-030 SHALL gate an overflow trap with macro ALU_ISSUE_OVF_TRAP_EN.
REQ-031 SHALL, without ALU_ISSUE_OVF_TRAP_EN, pass out_overflow through and keep out_wr_en=1 for all legal ops.
REQ-032 SHALL, with ALU_ISSUE_OVF_TRAP_EN, force out_wr_en=0 when ADD or SUB (signed only) captures alu_overflow=1; ADDU and SUBU are never trapped.

Structure
REQ-033 SHALL place op_code constants, the funct legality list and the FSM state encoding in shared package alu_pkg.
REQ-034 SHALL implement decode (legality and operand select) as combinational sub-module alu_funct_decode.

Verification
REQ-035 SHALL check ADD with rs=100, rt=45 -> alu_op_code=100000; out_result=145, out_zero=0, out_rd=instr[15:11], out_valid 3 edges after accept.
REQ-036 SHALL check SUB with rs=45, rt=45 -> out_result=0, out_zero=1, out_wr_en=1.
REQ-037 SHALL check SLL with rt=1 and shamt 0, 1, 5, 31 -> alu_operand1=1, alu_operand2=shamt, out_result=1<<shamt.
REQ-038 SHALL check ADD with rs=0x7FFFFFFF, rt=1 -> out_overflow=1; out_wr_en=0 with the macro, 1 without.
REQ-039 SHALL check funct=111111 -> out_illegal=1, issue_count unchanged; and out_ready=0 for 5 cycles -> out_* stable, in_ready=0.
REQ-040 SHALL check rst_n low during CAPTURE -> all outputs 0 immediately, next accept behaves normally.
